// File: rtl/placar_partida_pkg.sv
// Shared types for the match scoreboard: FSM states and winner encodings.
package placar_pkg;

  typedef enum logic {
    JOGANDO = 1'b0,
    FIM     = 1'b1
  } estado_t;

  localparam logic [1:0] VENC_NENHUM = 2'b00;
  localparam logic [1:0] VENC_P1     = 2'b01;
  localparam logic [1:0] VENC_P2     = 2'b10;
  localparam logic [1:0] VENC_EMPATE = 2'b11;

endpackage

// File: rtl/placar_partida_detector_borda.sv
// Rising-edge detector for a victory level: one pulse per 0->1 transition.
module detector_borda (
  input  logic clock,
  input  logic reset,
  input  logic in,
  output logic pulso
);

  logic hist_q;
  logic hist_d;

  always_comb hist_d = in;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) hist_q <= 1'b0;
    else        hist_q <= hist_d;
  end

  assign pulso = in & ~hist_q;

endmodule

// File: rtl/placar_partida.sv
// Match scoreboard: per-player scores, end-of-match detection, winner latch and
// blinking LED bars (P1 fills from the MSB end, P2 from the LSB end).
module placar_partida
  import placar_pkg::*;
#(
  parameter int LED_W     = 16,
  parameter int PTS_MAX   = LED_W / 2,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           p1vic,
  input  logic                           p2vic,
  input  logic                           novo_jogo,
  output logic [LED_W-1:0]               LED,
  output logic [$clog2(PTS_MAX+1)-1:0]   p1pontos,
  output logic [$clog2(PTS_MAX+1)-1:0]   p2pontos,
  output logic                           fim_jogo,
  output logic [1:0]                     vencedor
);

  localparam int SW    = $clog2(PTS_MAX + 1);
  localparam int HALF  = LED_W / 2;
  localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [SW-1:0]    SCORE_MAX = SW'(PTS_MAX);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BLINK_DIV - 1);

  function automatic logic [HALF-1:0] termometro(input logic [SW-1:0] pts);
    logic [HALF-1:0] bar;
    for (int k = 0; k < HALF; k++) bar[k] = (k < int'(pts));
    return bar;
  endfunction

  logic p1_pulso, p2_pulso;

  detector_borda u_borda_p1 (.clock(clock), .reset(reset), .in(p1vic), .pulso(p1_pulso));
  detector_borda u_borda_p2 (.clock(clock), .reset(reset), .in(p2vic), .pulso(p2_pulso));

  estado_t          estado_q, estado_d;
  logic [SW-1:0]    p1_q, p1_d, p2_q, p2_d;
  logic [1:0]       venc_q, venc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             blink_q, blink_d;
  logic [LED_W-1:0] led_q, led_d;
  logic [HALF-1:0]  bar1, bar2;
  logic             on1, on2;

  always_comb begin
    estado_d = estado_q;
    p1_d     = p1_q;
    p2_d     = p2_q;
    venc_d   = venc_q;
    cnt_d    = cnt_q;
    blink_d  = blink_q;
    if (novo_jogo) begin
      estado_d = JOGANDO;
      p1_d     = '0;
      p2_d     = '0;
      venc_d   = VENC_NENHUM;
      cnt_d    = '0;
      blink_d  = 1'b0;
    end else if (estado_q == JOGANDO) begin
      if (p1_pulso && (p1_q < SCORE_MAX)) p1_d = p1_q + SW'(1);
      if (p2_pulso && (p2_q < SCORE_MAX)) p2_d = p2_q + SW'(1);
      if ((p1_d == SCORE_MAX) || (p2_d == SCORE_MAX)) begin
        estado_d = FIM;
        cnt_d    = '0;
        blink_d  = 1'b0;
        if ((p1_d == SCORE_MAX) && (p2_d == SCORE_MAX)) venc_d = VENC_EMPATE;
        else if (p1_d == SCORE_MAX)                     venc_d = VENC_P1;
        else                                            venc_d = VENC_P2;
      end
    end else begin
      if (cnt_q == CNT_LAST) begin
        cnt_d   = '0;
        blink_d = ~blink_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Display decode works from the registered state, so LED trails scores by one clock.
  always_comb begin
    bar1  = termometro(p1_q);
    bar2  = termometro(p2_q);
    on1   = (estado_q != FIM) || !venc_q[0] || blink_q;
    on2   = (estado_q != FIM) || !venc_q[1] || blink_q;
    led_d = '0;
    for (int k = 0; k < HALF; k++) begin
      led_d[LED_W-1-k] = bar1[k] & on1;
      led_d[k]         = bar2[k] & on2;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q <= JOGANDO;
      p1_q     <= '0;
      p2_q     <= '0;
      venc_q   <= VENC_NENHUM;
      cnt_q    <= '0;
      blink_q  <= 1'b0;
      led_q    <= '0;
    end else begin
      estado_q <= estado_d;
      p1_q     <= p1_d;
      p2_q     <= p2_d;
      venc_q   <= venc_d;
      cnt_q    <= cnt_d;
      blink_q  <= blink_d;
      led_q    <= led_d;
    end
  end

  assign LED      = led_q;
  assign p1pontos = p1_q;
  assign p2pontos = p2_q;
  assign fim_jogo = (estado_q == FIM);
  assign vencedor = venc_q;

endmodule

// File: tb/tb_placar_partida.sv
// Bench for placar_partida: a 16-LED/8-point board and an 8-LED/3-point board,
// both checked against a score/age based reference model.
module tb_placar_partida;

  localparam int BDIV = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic p1vic = 1'b0, p2vic = 1'b0, novo_jogo = 1'b0;
  logic a1vic = 1'b0, a2vic = 1'b0, anj = 1'b0;

  logic [15:0] led16;
  logic [3:0]  p1_16, p2_16;
  logic        fim16;
  logic [1:0]  venc16;
  logic [7:0]  led8;
  logic [1:0]  p1_8, p2_8;
  logic        fim8;
  logic [1:0]  venc8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  placar_partida #(.LED_W(16), .PTS_MAX(8), .BLINK_DIV(BDIV)) dut16 (
    .clock(clk), .reset(rst_n), .p1vic(p1vic), .p2vic(p2vic), .novo_jogo(novo_jogo),
    .LED(led16), .p1pontos(p1_16), .p2pontos(p2_16), .fim_jogo(fim16), .vencedor(venc16));

  placar_partida #(.LED_W(8), .PTS_MAX(3), .BLINK_DIV(BDIV)) dut8 (
    .clock(clk), .reset(rst_n), .p1vic(a1vic), .p2vic(a2vic), .novo_jogo(anj),
    .LED(led8), .p1pontos(p1_8), .p2pontos(p2_8), .fim_jogo(fim8), .vencedor(venc8));

  // Reference model: scores as integers, blink derived from cycles spent in the end state.
  typedef struct {
    int          p1;
    int          p2;
    bit          fim;
    logic [1:0]  venc;
    int          age;
    logic        prev1;
    logic        prev2;
    logic [15:0] led;
  } model_t;

  function automatic model_t model_zero();
    model_t z;
    z.p1 = 0; z.p2 = 0; z.fim = 1'b0; z.venc = 2'b00; z.age = 0;
    z.prev1 = 1'b0; z.prev2 = 1'b0; z.led = '0;
    return z;
  endfunction

  function automatic model_t model_next(model_t s, logic v1, logic v2, logic nj,
                                        int ledw, int pmax);
    model_t n = s;
    bit blink, on1, on2;
    blink = ((s.age / BDIV) % 2) == 1;
    on1 = !s.fim || !s.venc[0] || blink;
    on2 = !s.fim || !s.venc[1] || blink;
    n.led = '0;
    for (int k = 0; k < s.p1; k++) n.led[ledw-1-k] = on1;
    for (int k = 0; k < s.p2; k++) n.led[k] = on2;
    n.prev1 = v1;
    n.prev2 = v2;
    if (nj) begin
      n.p1 = 0; n.p2 = 0; n.fim = 1'b0; n.venc = 2'b00; n.age = 0;
    end else if (!s.fim) begin
      if (v1 && !s.prev1 && s.p1 < pmax) n.p1 = s.p1 + 1;
      if (v2 && !s.prev2 && s.p2 < pmax) n.p2 = s.p2 + 1;
      if (n.p1 == pmax || n.p2 == pmax) begin
        n.fim = 1'b1;
        n.venc = {n.p2 == pmax, n.p1 == pmax};
        n.age = 0;
      end
    end else begin
      n.age = s.age + 1;
    end
    return n;
  endfunction

  model_t m16, m8;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m16 <= model_zero();
      m8  <= model_zero();
    end else begin
      m16 <= model_next(m16, p1vic, p2vic, novo_jogo, 16, 8);
      m8  <= model_next(m8, a1vic, a2vic, anj, 8, 3);
    end
  end

  logic [26:0] obs16, exp16;
  logic [14:0] obs8, exp8;
  assign obs16 = {led16, p1_16, p2_16, fim16, venc16};
  assign exp16 = {m16.led, 4'(m16.p1), 4'(m16.p2), m16.fim, m16.venc};
  assign obs8  = {led8, p1_8, p2_8, fim8, venc8};
  assign exp8  = {m8.led[7:0], 2'(m8.p1), 2'(m8.p2), m8.fim, m8.venc};

  task automatic pulse16(input logic a, input logic b);
    p1vic = a; p2vic = b;
    repeat ($urandom_range(1, 2)) @(negedge clk);
    p1vic = 1'b0; p2vic = 1'b0;
    repeat ($urandom_range(1, 3)) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (obs16 !== 27'd0 || obs8 !== 15'd0) begin
      errors++;
      $display("FAIL reset: got16=%h got8=%h want all zero", obs16, obs8);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_hold();
    p1vic = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (obs16 !== exp16) begin
        errors++;
        $display("FAIL hold cycle %0d: got=%h want=%h", i, obs16, exp16);
      end
    end
    checks++;
    if (p1_16 !== 4'd1 || led16 !== 16'h8000) begin
      errors++;
      $display("FAIL hold_final: p1=%0d led=%h want p1=1 led=8000", p1_16, led16);
    end
    p1vic = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_p2_win();
    int ons = 0, offs = 0;
    for (int i = 0; i < 8; i++) pulse16(1'b0, 1'b1);
    checks++;
    if (p2_16 !== 4'd8 || fim16 !== 1'b1 || venc16 !== 2'b10) begin
      errors++;
      $display("FAIL p2_win: p2=%0d fim=%b venc=%b want 8 1 10", p2_16, fim16, venc16);
    end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      checks++;
      if (obs16 !== exp16 || led16[15:8] !== 8'h80 ||
          (led16[7:0] !== 8'hFF && led16[7:0] !== 8'h00)) begin
        errors++;
        $display("FAIL p2_blink cycle %0d: got=%h want=%h", i, obs16, exp16);
      end
      if (led16[7:0] === 8'hFF) ons++;
      if (led16[7:0] === 8'h00) offs++;
    end
    checks++;
    if (ons < 4 || offs < 4) begin
      errors++;
      $display("FAIL p2_toggle: on=%0d off=%0d want both >= 4", ons, offs);
    end
  endtask

  task automatic test_fim_ignore();
    pulse16(1'b1, 1'b0);
    pulse16(1'b0, 1'b1);
    checks++;
    if (p1_16 !== 4'd1 || p2_16 !== 4'd8 || venc16 !== 2'b10 || fim16 !== 1'b1) begin
      errors++;
      $display("FAIL fim_frozen: p1=%0d p2=%0d venc=%b want 1 8 10", p1_16, p2_16, venc16);
    end
    novo_jogo = 1'b1; p1vic = 1'b1;
    @(negedge clk);
    novo_jogo = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (obs16 !== 27'd0 || obs16 !== exp16) begin
      errors++;
      $display("FAIL novo_jogo: got=%h want=0 model=%h", obs16, exp16);
    end
    p1vic = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_tie();
    for (int r = 0; r < 7; r++) begin
      case ($urandom_range(0, 2))
        0: pulse16(1'b1, 1'b1);
        1: begin pulse16(1'b1, 1'b0); pulse16(1'b0, 1'b1); end
        default: begin pulse16(1'b0, 1'b1); pulse16(1'b1, 1'b0); end
      endcase
    end
    checks++;
    if (p1_16 !== 4'd7 || p2_16 !== 4'd7 || fim16 !== 1'b0) begin
      errors++;
      $display("FAIL tie_setup: p1=%0d p2=%0d fim=%b want 7 7 0", p1_16, p2_16, fim16);
    end
    pulse16(1'b1, 1'b1);
    checks++;
    if (p1_16 !== 4'd8 || p2_16 !== 4'd8 || venc16 !== 2'b11 || fim16 !== 1'b1) begin
      errors++;
      $display("FAIL tie: p1=%0d p2=%0d venc=%b want 8 8 11", p1_16, p2_16, venc16);
    end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checks++;
      if (obs16 !== exp16 || (led16 !== 16'hFFFF && led16 !== 16'h0000)) begin
        errors++;
        $display("FAIL tie_blink cycle %0d: got=%h want=%h", i, obs16, exp16);
      end
    end
    novo_jogo = 1'b1;
    @(negedge clk);
    novo_jogo = 1'b0;
  endtask

  task automatic test_small();
    int ons = 0, offs = 0;
    anj = 1'b1;
    @(negedge clk);
    anj = 1'b0;
    for (int i = 0; i < 2; i++) begin
      a1vic = 1'b1; @(negedge clk); a1vic = 1'b0; @(negedge clk);
    end
    checks++;
    if (led8 !== 8'b1100_0000 || p1_8 !== 2'd2) begin
      errors++;
      $display("FAIL small_two: led=%b p1=%0d want 11000000 2", led8, p1_8);
    end
    a1vic = 1'b1; @(negedge clk); a1vic = 1'b0;
    checks++;
    if (venc8 !== 2'b01 || fim8 !== 1'b1 || p1_8 !== 2'd3) begin
      errors++;
      $display("FAIL small_win: venc=%b fim=%b p1=%0d want 01 1 3", venc8, fim8, p1_8);
    end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checks++;
      if (obs8 !== exp8 || led8[4:3] !== 2'b00 ||
          (led8 !== 8'b1110_0000 && led8 !== 8'h00)) begin
        errors++;
        $display("FAIL small_blink cycle %0d: got=%h want=%h", i, obs8, exp8);
      end
      if (led8 === 8'b1110_0000) ons++;
      if (led8 === 8'h00) offs++;
    end
    checks++;
    if (ons < 4 || offs < 4) begin
      errors++;
      $display("FAIL small_toggle: on=%0d off=%0d want both >= 4", ons, offs);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      p1vic = ($urandom_range(0, 2) == 0) ? ~p1vic : p1vic;
      p2vic = ($urandom_range(0, 2) == 0) ? ~p2vic : p2vic;
      a1vic = ($urandom_range(0, 1) == 0) ? ~a1vic : a1vic;
      a2vic = ($urandom_range(0, 1) == 0) ? ~a2vic : a2vic;
      novo_jogo = ($urandom_range(0, 39) == 0);
      anj = ($urandom_range(0, 29) == 0);
      @(negedge clk);
      checks++;
      if (obs16 !== exp16 || obs8 !== exp8) begin
        errors++;
        $display("FAIL random cycle %0d: got16=%h want16=%h got8=%h want8=%h",
                 i, obs16, exp16, obs8, exp8);
      end
    end
    p1vic = 1'b0; p2vic = 1'b0; a1vic = 1'b0; a2vic = 1'b0;
    novo_jogo = 1'b0; anj = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    pulse16(1'b1, 1'b0);
    pulse16(1'b0, 1'b1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (obs16 !== 27'd0 || obs8 !== 15'd0) begin
      errors++;
      $display("FAIL async_reset: got16=%h got8=%h want all zero", obs16, obs8);
    end
    p1vic = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (p1_16 !== 4'd1 || obs16 !== exp16) begin
      errors++;
      $display("FAIL reset_release: p1=%0d want 1 (got=%h model=%h)", p1_16, obs16, exp16);
    end
    p1vic = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_hold();
    test_p2_win();
    test_fim_ignore();
    test_tie();
    test_small();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
